// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: single-port text VRAM arbiter, display > clear > CPU priority.
// Define VGA_VRAM_CLR_EN to build in the hardware clear-screen engine.
module vga_vram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CELLS = 2400,
  parameter logic [DATA_W-1:0] CLR_VALUE = 16'h0720
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU, T_CLR} tag_t;
  tag_t tag1, tag2;
  logic oor1, oor2;
  logic idle, clr_g, cpu_acc, cpu_in;
  logic [ADDR_W-1:0] clr_addr;
  assign cpu_in = cpu_addr < ADDR_W'(CELLS);
  assign cpu_req_ready = reset & ~disp_req & idle;
  assign cpu_acc = cpu_req_valid & cpu_req_ready;
`ifdef VGA_VRAM_CLR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic clr_last;
  assign clr_last = clr_ptr == ADDR_W'(CELLS - 1);
  assign clr_addr = clr_ptr;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (clr_start ? CLEAR : IDLE) : ((clr_g && clr_last) ? IDLE : CLEAR);
  always_comb begin
    idle = state == IDLE;
    clr_busy = state == CLEAR;
    clr_g = (state == CLEAR) & ~disp_req;
  end
  // A display fetch stalls the engine: pointer only moves on an actual write.
  always_ff @(posedge clk)
    if (!reset) clr_ptr <= '0;
    else if (clr_g) clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
`else
  logic unused_clr;
  assign unused_clr = clr_start;
  assign idle = 1'b1;
  assign clr_busy = 1'b0;
  assign clr_g = 1'b0;
  assign clr_addr = '0;
`endif
  // Out-of-range CPU reads still carry a CPU tag so the response pulse appears, with zero data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      tag1 <= T_NONE;
      tag2 <= T_NONE;
      oor1 <= 1'b0;
      oor2 <= 1'b0;
      disp_valid <= 1'b0;
      cpu_rsp_valid <= 1'b0;
    end else begin
      ram_en <= disp_req | clr_g | (cpu_acc & cpu_in);
      ram_we <= clr_g | (cpu_acc & cpu_we & cpu_in);
      ram_addr <= disp_req ? disp_addr : clr_g ? clr_addr : cpu_addr;
      ram_wdata <= clr_g ? CLR_VALUE : cpu_wdata;
      tag1 <= disp_req ? T_DISP : clr_g ? T_CLR : (cpu_acc & ~cpu_we) ? T_CPU : T_NONE;
      oor1 <= ~cpu_in;
      tag2 <= tag1;
      oor2 <= oor1;
      disp_valid <= tag1 == T_DISP;
      cpu_rsp_valid <= tag1 == T_CPU;
    end
  end
  assign disp_rdata = (tag2 == T_DISP) ? ram_rdata : '0;
  assign cpu_rdata = (tag2 == T_CPU && !oor2) ? ram_rdata : '0;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed and randomized checks of vga_vram_arbiter against a cycle-level
// reference model; clear-engine scenarios are included when VGA_VRAM_CLR_EN is defined.
module tb_vga_vram_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int CELLS = 2400;
  localparam logic [DW-1:0] CLRV = 16'h0720;
`ifdef VGA_VRAM_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  logic clk = 0, reset = 0, disp_req = 0, cpu_req_valid = 0, cpu_we = 0, clr_start = 0;
  logic [AW-1:0] disp_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic disp_valid, cpu_req_ready, cpu_rsp_valid, clr_busy, ram_en, ram_we;
  logic [DW-1:0] disp_rdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  vga_vram_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  // VRAM block: 1-cycle synchronous read, unwritten cells hold a known pattern
  logic [DW-1:0] vram [4096];
  bit wr_ok [4096];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        vram[ram_addr] <= ram_wdata;
        wr_ok[ram_addr] <= 1'b1;
      end
      ram_rdata <= wr_ok[ram_addr] ? vram[ram_addr] : init_val(ram_addr);
    end

  // Reference model: one grant per cycle, RAM port one cycle later, read data one cycle after that
  logic [DW-1:0] ref_mem [4096];
  int cyc = 0;
  bit started = 0;
  bit m_busy = 0;
  int m_ptr = 0;
  bit m_en = 0, m_we = 0, m_dv = 0, m_cv = 0, n_dv = 0, n_cv = 0, cpu_took = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_dd = '0, m_cd = '0, n_dd = '0, n_cd = '0;

  always @(posedge clk) begin : model
    bit was_busy;
    if (!started) for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    started = 1;
    cyc++;
    was_busy = m_busy;
    m_dv = n_dv; m_cv = n_cv; m_dd = n_dd; m_cd = n_cd;
    n_dv = 0; n_cv = 0; n_dd = '0; n_cd = '0;
    m_en = 0; m_we = 0; m_addr = '0; m_wd = '0; cpu_took = 0;
    if (!reset) begin
      m_dv = 0; m_cv = 0; m_dd = '0; m_cd = '0; m_busy = 0; m_ptr = 0;
    end else if (disp_req) begin
      m_en = 1; m_addr = disp_addr; n_dv = 1; n_dd = ref_mem[disp_addr];
    end else if (m_busy) begin
      m_en = 1; m_we = 1; m_addr = 12'(m_ptr); m_wd = CLRV; ref_mem[m_ptr] = CLRV;
      m_ptr++;
      if (m_ptr == CELLS) begin m_busy = 0; m_ptr = 0; end
    end else if (cpu_req_valid) begin
      cpu_took = 1;
      if (cpu_addr < CELLS) begin
        m_en = 1; m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata;
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      end
      if (!cpu_we) begin
        n_cv = 1;
        n_cd = (cpu_addr < CELLS) ? ref_mem[cpu_addr] : '0;
      end
    end
    if (CLR_EN && reset && !was_busy && clr_start) m_busy = 1;
  end

  // Literal expectations posted by the stimulus for a specific cycle
  string pin_nm [4];
  int pin_k [4];
  logic [31:0] pin_e [4];
  int pin_n = 0, pin_at = -1;
  logic [31:0] pin_v = '0, pin_w = '0;

  function automatic logic [31:0] pin_act(int k);
    case (k)
      0: return 32'(cpu_req_ready);
      1: return 32'(ram_en);
      2: return 32'(disp_valid);
      3: return 32'(cpu_rsp_valid);
      4: return 32'(cpu_rdata);
      5: return 32'(disp_rdata);
      6: return 32'(clr_busy);
      7: return pin_v;
      default: return pin_w;
    endcase
  endfunction

  int n_vec = 0, n_bad = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk)
    if (started) begin
      chk("cpu_req_ready", 32'(cpu_req_ready), 32'(reset && !disp_req && !m_busy));
      chk("ram_en", 32'(ram_en), 32'(m_en));
      if (m_en) begin
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        if (m_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_wd));
      end
      chk("disp_valid", 32'(disp_valid), 32'(m_dv));
      chk("disp_rdata", 32'(disp_rdata), 32'(m_dd));
      chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(m_cv));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cd));
      chk("clr_busy", 32'(clr_busy), 32'(m_busy));
      if (pin_at == cyc)
        for (int i = 0; i < pin_n; i++) chk(pin_nm[i], pin_act(pin_k[i]), pin_e[i]);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int k, input logic [31:0] e);
    if (pin_at != cyc) begin
      pin_n = 0;
      pin_at = cyc;
    end
    pin_nm[pin_n] = nm;
    pin_k[pin_n] = k;
    pin_e[pin_n] = e;
    pin_n++;
  endtask

  // Returns in the cycle after acceptance
  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    g = 0;
    cpu_req_valid = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    do begin
      tick();
      g++;
    end while (!cpu_took && g < 50);
    cpu_req_valid = 0;
    if (!cpu_took) begin
      pin_v = 32'(cpu_took);
      pin("cpu_accept_timeout", 7, 1);
    end
  endtask

  initial begin
    // reset held low with a pending CPU request
    reset = 0; cpu_req_valid = 1; cpu_we = 0; cpu_addr = 12'h005;
    tick(); tick(); tick();
    pin("rst_ready", 0, 0); pin("rst_ram_en", 1, 0); pin("rst_disp_valid", 2, 0); pin("rst_rsp_valid", 3, 0);
    tick();
    reset = 1; cpu_req_valid = 0;
    tick();
    // write then read back
    cpu_op(1, 12'h005, 16'h1F41);
    cpu_op(0, 12'h005, 16'h0000);
    tick();
    pin("rd005_valid", 3, 1); pin("rd005_data", 4, 32'h1F41);
    // display request collides with CPU request
    cpu_op(1, 12'h010, 16'hABCD);
    cpu_op(1, 12'h020, 16'h1234);
    disp_req = 1; disp_addr = 12'h010;
    cpu_req_valid = 1; cpu_we = 0; cpu_addr = 12'h020;
    pin("ready_vs_disp", 0, 0);
    tick();
    disp_req = 0;
    pin("ready_after_disp", 0, 1);
    tick();
    pin_v = 32'(cpu_took);
    pin("cpu_accept_after_disp", 7, 1); pin("disp_valid_lat2", 2, 1); pin("disp_data_010", 5, 32'hABCD);
    cpu_req_valid = 0;
    tick();
    pin("rd020_valid", 3, 1); pin("rd020_data", 4, 32'h1234);
    // out-of-range accesses
    cpu_op(1, 12'd2400, 16'hBEEF);
    pin("oor_wr_ram_en", 1, 0);
    cpu_op(0, 12'd2400, 16'h0000);
    tick();
    pin("oor_rd_valid", 3, 1); pin("oor_rd_data", 4, 0);
`ifdef VGA_VRAM_CLR_EN
    begin
      int k, nw, g;
      k = 0; nw = 0;
      clr_start = 1;
      tick();
      clr_start = 0;
      while (clr_busy && k < 4000) begin
        if (ram_en && ram_we && ram_wdata == CLRV) nw++;
        disp_req = (k % 8 == 7); disp_addr = 12'(k);
        tick();
        k++;
      end
      disp_req = 0;
      if (ram_en && ram_we && ram_wdata == CLRV) nw++;
      pin_v = k; pin_w = nw;
      pin("clr_busy_cycles", 7, 2742); pin("clr_writes", 8, 2400);
      cpu_op(0, 12'd2399, 16'h0000);
      tick();
      pin("clr_cell_2399", 4, 32'h0720);
      // reset aborts the engine part-way
      cpu_op(1, 12'd101, 16'h5555);
      cpu_op(1, 12'd99, 16'h6666);
      clr_start = 1;
      tick();
      clr_start = 0;
      g = 0;
      while (m_ptr != 100 && g < 500) begin
        tick();
        g++;
      end
      reset = 0;
      tick();
      reset = 1;
      pin("abort_busy", 6, 0);
      cpu_op(0, 12'd101, 16'h0000);
      tick();
      pin("abort_cell_101", 4, 32'h5555);
      cpu_op(0, 12'd99, 16'h0000);
      tick();
      pin("abort_cell_99", 4, 32'h0720);
    end
`endif
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (cpu_took) cpu_req_valid = 0;
      if (!cpu_req_valid && $urandom_range(2) == 0) begin
        cpu_req_valid = 1;
        cpu_we = 1'($urandom_range(1));
        cpu_addr = ($urandom_range(9) == 0) ? 12'(2400 + $urandom_range(1695)) : 12'($urandom_range(63));
        cpu_wdata = 16'($urandom);
      end
      disp_req = ($urandom_range(9) < 3);
      disp_addr = 12'($urandom);
      reset = ($urandom_range(199) != 0);
      clr_start = ($urandom_range(999) == 0);
    end
    reset = 1; disp_req = 0; cpu_req_valid = 0; clr_start = 0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
